move_input_controller: RTL

- Input-side counterpart of the VGA display path: converts five raw push-buttons into the cursor/selection signals the display consumes (CURSOR_ADDR, SELECT_ADDR, SELECT_EN).
- Issues a from/to move request to the board-update logic over a valid/ready handshake.
- Reads the same 256-bit BOARD bus, so only pieces of the side to move can be selected.

---
 rtl/chess_pkg.sv | 38 +++
 rtl/move_input_controller_if.sv | 12 +
 rtl/button_debounce.sv | 60 ++++++
 rtl/move_input_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared board encoding, square addressing, FSM states and button priority
// for the move input controller.
package chess_pkg;

   localparam int         PIECE_W   = 4;
   localparam logic [3:0] EMPTY     = 4'd0;
   localparam int         COLOR_BIT = 3;

   localparam int SQ_W    = 6;
   localparam int ROW_MSB = 5;
   localparam int ROW_LSB = 3;
   localparam int COL_MSB = 2;
   localparam int COL_LSB = 0;

   typedef enum logic [1:0] {IDLE, SELECTED, COMMIT} fsm_state_t;

   // Button vector index doubles as priority rank: lower index wins.
   localparam int NUM_BTN    = 5;
   localparam int IDX_CENTER = 0;
   localparam int IDX_UP     = 1;
   localparam int IDX_DOWN   = 2;
   localparam int IDX_LEFT   = 3;
   localparam int IDX_RIGHT  = 4;

   typedef enum logic [2:0] {
      ACT_NONE, ACT_CENTER, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT
   } action_t;

   function automatic action_t pick_action(input logic [NUM_BTN-1:0] p);
      if (p[IDX_CENTER]) return ACT_CENTER;
      if (p[IDX_UP])     return ACT_UP;
      if (p[IDX_DOWN])   return ACT_DOWN;
      if (p[IDX_LEFT])   return ACT_LEFT;
      if (p[IDX_RIGHT])  return ACT_RIGHT;
      return ACT_NONE;
   endfunction

endpackage

// File: rtl/move_input_controller_if.sv
// Move request handshake from the input controller to the board-update logic.
interface move_input_controller_if;
   import chess_pkg::*;

   logic [SQ_W-1:0] MOVE_FROM;
   logic [SQ_W-1:0] MOVE_TO;
   logic            MOVE_VALID;
   logic            MOVE_READY;

   modport master (output MOVE_FROM, output MOVE_TO, output MOVE_VALID, input MOVE_READY);
   modport slave  (input MOVE_FROM, input MOVE_TO, input MOVE_VALID, output MOVE_READY);
endinterface

// File: rtl/button_debounce.sv
// Synchronizer + stability debounce + rising-edge press pulse for one button.
// Optional auto-repeat while held is built only when HOLD_REPEAT_EN is defined.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press,
   output logic rpt
);
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level, level_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync    <= {sync[0], btn};
         level_d <= level;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level & ~level_d;

`ifdef HOLD_REPEAT_EN
   localparam int            RW      = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rcnt;

   // Counter restarts on each emitted step so repeats land every REPEAT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     rcnt <= '0;
      else if (!level || press || rpt) rcnt <= '0;
      else                             rcnt <= rcnt + 1'b1;
   end

   assign rpt = level && !press && (rcnt == RPT_MAX);
`else
   assign rpt = 1'b0;
`endif

endmodule

// File: rtl/move_input_controller.sv
// Turns five push-buttons into cursor/selection state and a from/to move request.
// Define HOLD_REPEAT_EN to enable auto-repeat on held direction buttons.
module move_input_controller
   import chess_pkg::*;
#(
   parameter int              DEBOUNCE_CYCLES = 250000,
   parameter logic [SQ_W-1:0] CURSOR_INIT     = 6'd12,
   parameter int              REPEAT_CYCLES   = 12500000
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             BTN_UP,
   input  logic             BTN_DOWN,
   input  logic             BTN_LEFT,
   input  logic             BTN_RIGHT,
   input  logic             BTN_CENTER,
   input  logic [255:0]     BOARD,
   input  logic             TURN,
   output logic [SQ_W-1:0]  CURSOR_ADDR,
   output logic [SQ_W-1:0]  SELECT_ADDR,
   output logic             SELECT_EN,
   move_input_controller_if.master mv
);
   localparam logic [NUM_BTN-1:0] RPT_MASK = ~(NUM_BTN'(1) << IDX_CENTER);

   logic [NUM_BTN-1:0] btn_raw, press, rpt, pulse;
   assign btn_raw = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP, BTN_CENTER};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_db (
         .clk   (CLK),
         .rst_n (RESET),
         .btn   (btn_raw[i]),
         .press (press[i]),
         .rpt   (rpt[i])
      );
   end

   assign pulse = press | (rpt & RPT_MASK);

   action_t              act;
   fsm_state_t           state;
   logic [PIECE_W-1:0]   cur_piece;
   logic                 own;
   logic [2:0]           row, col;

   assign act       = pick_action(pulse);
   assign cur_piece = BOARD[{CURSOR_ADDR, 2'b00} +: PIECE_W];
   assign own       = (cur_piece != EMPTY) && (cur_piece[COLOR_BIT] == TURN);
   assign row       = CURSOR_ADDR[ROW_MSB:ROW_LSB];
   assign col       = CURSOR_ADDR[COL_MSB:COL_LSB];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         CURSOR_ADDR   <= CURSOR_INIT;
         SELECT_ADDR   <= '0;
         SELECT_EN     <= 1'b0;
         mv.MOVE_FROM  <= '0;
         mv.MOVE_TO    <= '0;
         mv.MOVE_VALID <= 1'b0;
         state         <= IDLE;
      end else begin
         // 3-bit row/col fields wrap naturally at the board edge.
         if (state != COMMIT) begin
            case (act)
               ACT_UP:    CURSOR_ADDR <= {row + 3'd1, col};
               ACT_DOWN:  CURSOR_ADDR <= {row - 3'd1, col};
               ACT_RIGHT: CURSOR_ADDR <= {row, col + 3'd1};
               ACT_LEFT:  CURSOR_ADDR <= {row, col - 3'd1};
               default: ;
            endcase
         end
         case (state)
            IDLE: begin
               if (act == ACT_CENTER && own) begin
                  SELECT_ADDR <= CURSOR_ADDR;
                  SELECT_EN   <= 1'b1;
                  state       <= SELECTED;
               end
            end
            SELECTED: begin
               if (act == ACT_CENTER) begin
                  if (CURSOR_ADDR == SELECT_ADDR) begin
                     SELECT_EN <= 1'b0;
                     state     <= IDLE;
                  end else if (own) begin
                     SELECT_ADDR <= CURSOR_ADDR;
                  end else begin
                     mv.MOVE_FROM  <= SELECT_ADDR;
                     mv.MOVE_TO    <= CURSOR_ADDR;
                     mv.MOVE_VALID <= 1'b1;
                     state         <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               if (mv.MOVE_READY) begin
                  mv.MOVE_VALID <= 1'b0;
                  SELECT_EN     <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
